// File: rtl/calendar_ctrl.sv
// -----------------------------------------------------------------------------
// calendar_ctrl
// Day/month calendar sequencer and RUN/SET mode controller for the century
// clock. Advances day/month on each midnight tick, requests a year rollover
// on Dec 31, and lets the user edit day, month and year via two buttons.
//
// Build option: define GREGORIAN_FULL_EN for the full Gregorian leap rule
// (%4, %100, %400). Without it, leap = (year[1:0] == 0).
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   tick_day   in   one-cycle midnight carry from the hour counter
//   btn_mode   in   debounced level; rising edge advances the mode
//   btn_inc    in   debounced level; rising edge increments selected field
//   year       in   current year from the year counter (YEAR_W bits)
//   day        out  day of month, 1..31
//   month      out  month, 1..12
//   mode       out  0=RUN, 1=SET_DAY, 2=SET_MONTH, 3=SET_YEAR
//   count_year out  one-cycle year rollover request
//   set_year   out  one-cycle user year increment request
// -----------------------------------------------------------------------------
module calendar_ctrl #(
  parameter int YEAR_W     = 16,
  parameter int INIT_DAY   = 1,
  parameter int INIT_MONTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_day,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic [YEAR_W-1:0] year,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [1:0]        mode,
  output logic              count_year,
  output logic              set_year
);

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_DAY   = 2'd1,
    MODE_SET_MONTH = 2'd2,
    MODE_SET_YEAR  = 2'd3
  } mode_t;

  mode_t      r_mode;
  mode_t      w_mode_next;
  logic [4:0] r_day;
  logic [3:0] r_month;
  logic       r_count_year;
  logic       r_set_year;
  logic       r_btn_mode_q;
  logic       r_btn_inc_q;

  logic [4:0] w_day_next;
  logic [3:0] w_month_next;
  logic       w_count_year_next;
  logic       w_set_year_next;
  logic       w_day_upd;
  logic       w_mode_rise;
  logic       w_inc_rise;
  logic       w_inc_take;
  logic       w_leap;
  logic [4:0] w_dim;

  assign w_mode_rise = btn_mode & ~r_btn_mode_q;
  assign w_inc_rise  = btn_inc & ~r_btn_inc_q;
  // A mode step in the same cycle swallows the increment.
  assign w_inc_take  = w_inc_rise & ~w_mode_rise;

`ifdef GREGORIAN_FULL_EN
  assign w_leap = (year[1:0] == 2'b00) &&
                  (((year % YEAR_W'(100)) != '0) || ((year % YEAR_W'(400)) == '0));
`else
  // Upper year bits are irrelevant to the simplified rule.
  logic w_unused_year;
  assign w_unused_year = ^year[YEAR_W-1:2];
  assign w_leap = (year[1:0] == 2'b00);
`endif

  always_comb begin
    case (r_month)
      4'd2:                      w_dim = w_leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   w_dim = 5'd30;
      default:                   w_dim = 5'd31;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mode <= MODE_RUN;
    else        r_mode <= w_mode_next;
  end

  // FSM next-state logic: one step around the ring per mode_rise
  always_comb begin
    w_mode_next = r_mode;
    if (w_mode_rise) begin
      case (r_mode)
        MODE_RUN:       w_mode_next = MODE_SET_DAY;
        MODE_SET_DAY:   w_mode_next = MODE_SET_MONTH;
        MODE_SET_MONTH: w_mode_next = MODE_SET_YEAR;
        default:        w_mode_next = MODE_RUN;
      endcase
    end
  end

  // FSM output logic: next values of the calendar and the pulse outputs
  always_comb begin
    w_day_next        = r_day;
    w_month_next      = r_month;
    w_count_year_next = 1'b0;
    w_set_year_next   = 1'b0;
    w_day_upd         = 1'b0;
    case (r_mode)
      MODE_RUN: begin
        if (tick_day) begin
          w_day_upd = 1'b1;
          if (r_day < w_dim) begin
            w_day_next = r_day + 5'd1;
          end else begin
            w_day_next = 5'd1;
            if (r_month < 4'd12) begin
              w_month_next = r_month + 4'd1;
            end else begin
              w_month_next      = 4'd1;
              w_count_year_next = 1'b1;
            end
          end
        end
      end
      MODE_SET_DAY: begin
        if (w_inc_take) begin
          w_day_upd  = 1'b1;
          w_day_next = (r_day >= w_dim) ? 5'd1 : r_day + 5'd1;
        end
      end
      MODE_SET_MONTH: begin
        if (w_inc_take) w_month_next = (r_month >= 4'd12) ? 4'd1 : r_month + 4'd1;
      end
      default: begin
        if (w_inc_take) w_set_year_next = 1'b1;
      end
    endcase
    // Pull an out-of-range day back after a month or year change; this uses
    // the current month/year, so it lands one cycle after that change.
    if (!w_day_upd && (r_day > w_dim)) w_day_next = w_dim;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_day        <= 5'(INIT_DAY);
      r_month      <= 4'(INIT_MONTH);
      r_count_year <= 1'b0;
      r_set_year   <= 1'b0;
      r_btn_mode_q <= 1'b0;
      r_btn_inc_q  <= 1'b0;
    end else begin
      r_day        <= w_day_next;
      r_month      <= w_month_next;
      r_count_year <= w_count_year_next;
      r_set_year   <= w_set_year_next;
      r_btn_mode_q <= btn_mode;
      r_btn_inc_q  <= btn_inc;
    end
  end

  assign day        = r_day;
  assign month      = r_month;
  assign mode       = r_mode;
  assign count_year = r_count_year;
  assign set_year   = r_set_year;

endmodule

// File: tb/tb_calendar_ctrl.sv
// -----------------------------------------------------------------------------
// tb_calendar_ctrl
// Self-checking bench for calendar_ctrl. Emulates the year counter (increments
// one edge after a count_year/set_year pulse) and keeps a calendar reference
// model built from the date rules with plain integer arithmetic. Directed
// scenarios are followed by a randomized button/tick phase.
// -----------------------------------------------------------------------------
module tb_calendar_ctrl;

  localparam int P_YEAR_W     = 16;
  localparam int P_INIT_DAY   = 1;
  localparam int P_INIT_MONTH = 1;

  logic                clk;
  logic                rst_n;
  logic                tick_day;
  logic                btn_mode;
  logic                btn_inc;
  logic [P_YEAR_W-1:0] year_r;
  logic [4:0]          day;
  logic [3:0]          month;
  logic [1:0]          mode;
  logic                count_year;
  logic                set_year;

  calendar_ctrl #(
    .YEAR_W    (P_YEAR_W),
    .INIT_DAY  (P_INIT_DAY),
    .INIT_MONTH(P_INIT_MONTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_day  (tick_day),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .year      (year_r),
    .day       (day),
    .month     (month),
    .mode      (mode),
    .count_year(count_year),
    .set_year  (set_year)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // reference model state
  int m_day, m_month, m_mode;
  bit m_cy, m_sy, m_bm, m_bi;
  bit yr_pend;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit is_leap(input int y);
`ifdef GREGORIAN_FULL_EN
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
`else
    return (y % 4 == 0);
`endif
  endfunction

  function automatic int days_in(input int m, input int y);
    if (m == 2) return is_leap(y) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic model_reset();
    m_day = P_INIT_DAY; m_month = P_INIT_MONTH; m_mode = 0;
    m_cy = 0; m_sy = 0; m_bm = 0; m_bi = 0;
  endtask

  task automatic check_all();
    check("day", int'(day), m_day);
    check("month", int'(month), m_month);
    check("mode", int'(mode), m_mode);
    check("count_year", int'(count_year), int'(m_cy));
    check("set_year", int'(set_year), int'(m_sy));
  endtask

  // one clock cycle: drive at negedge, advance model at posedge, compare after
  task automatic step(input bit t, input bit bm, input bit bi);
    bit mr, ir, upd;
    int dm;
    @(negedge clk);
    if (yr_pend) begin
      year_r  = year_r + 16'd1;
      yr_pend = 0;
    end
    tick_day = t; btn_mode = bm; btn_inc = bi;
    @(posedge clk);
    cyc++;
    if (m_cy || m_sy) yr_pend = 1;  // year counter acts on this edge
    mr = bm && !m_bm;
    ir = bi && !m_bi && !mr;
    m_bm = bm; m_bi = bi;
    dm = days_in(m_month, int'(year_r));
    m_cy = 0; m_sy = 0; upd = 0;
    if (m_mode == 0) begin
      if (t) begin
        upd = 1;
        if (m_day < dm) m_day = m_day + 1;
        else begin
          m_day = 1;
          if (m_month == 12) begin m_month = 1; m_cy = 1; end
          else m_month = m_month + 1;
        end
      end
    end else if (ir) begin
      if (m_mode == 1) begin upd = 1; m_day = (m_day >= dm) ? 1 : m_day + 1; end
      else if (m_mode == 2) m_month = m_month % 12 + 1;
      else m_sy = 1;
    end
    if (!upd && m_day > dm) m_day = dm;
    if (mr) m_mode = (m_mode + 1) % 4;
    #1;
    check_all();
  endtask

  task automatic press_mode();
    step(0, 1, 0);
    step(0, 0, 0);
  endtask

  task automatic press_inc();
    step(0, 0, 1);
    step(0, 0, 0);
  endtask

  // from RUN: set month then day through the button UI, end back in RUN
  task automatic set_date(input int d, input int m);
    int n;
    press_mode();                       // SET_DAY
    press_mode();                       // SET_MONTH
    n = 0;
    while (m_month != m && n < 20) begin press_inc(); n++; end
    press_mode();                       // SET_YEAR
    press_mode();                       // RUN
    press_mode();                       // SET_DAY
    n = 0;
    while (m_day != d && n < 40) begin press_inc(); n++; end
    press_mode(); press_mode(); press_mode();
    check("set_date_day", int'(day), d);
    check("set_date_month", int'(month), m);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    model_reset();
    check("rst_day", int'(day), P_INIT_DAY);
    check("rst_month", int'(month), P_INIT_MONTH);
    check("rst_mode", int'(mode), 0);
    check("rst_count_year", int'(count_year), 0);
    check("rst_set_year", int'(set_year), 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int yrs[6];
    yrs = '{1900, 2000, 2023, 2024, 2100, 0};
    rst_n = 0; tick_day = 0; btn_mode = 0; btn_inc = 0;
    year_r = 16'd2024; yr_pend = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clk); rst_n = 1;

    // 31 ticks from Jan 1
    for (int i = 0; i < 31; i++) step(1, 0, 0);
    check("jan_rollover_day", int'(day), 1);
    check("jan_rollover_month", int'(month), 2);
    $display("scenario: 31 ticks -> %0d/%0d", day, month);

    // Dec 31 -> Jan 1 with one-cycle count_year
    set_date(31, 12);
    step(1, 0, 0);
    check("dec31_day", int'(day), 1);
    check("dec31_month", int'(month), 1);
    check("dec31_count_year", int'(count_year), 1);
    step(0, 0, 0);
    check("dec31_count_year_drop", int'(count_year), 0);
    step(0, 0, 0); step(0, 0, 0);
    $display("scenario: dec31 rollover, year now %0d", year_r);

    // leap year February
    year_r = 16'd2024;
    set_date(28, 2);
    step(1, 0, 0); check("leap2024_day", int'(day), 29);
    step(1, 0, 0); check("leap2024_mar", int'(month), 3);
    $display("scenario: feb 2024 -> %0d/%0d", day, month);
    year_r = 16'd2023;
    set_date(28, 2);
    step(1, 0, 0); check("feb2023_day", int'(day), 1);
    check("feb2023_month", int'(month), 3);
    $display("scenario: feb 2023 -> %0d/%0d", day, month);
    year_r = 16'd1900;
    set_date(28, 2);
    step(1, 0, 0);
`ifdef GREGORIAN_FULL_EN
    check("feb1900_day", int'(day), 1);
`else
    check("feb1900_day", int'(day), 29);
`endif
    $display("scenario: feb 1900 -> %0d/%0d", day, month);

    // month edit clamps day one cycle later
    year_r = 16'd2023;
    set_date(31, 1);
    press_mode(); press_mode();
    step(0, 0, 1);
    check("clamp_month", int'(month), 2);
    check("clamp_before", int'(day), 31);
    step(0, 0, 0);
    check("clamp_after", int'(day), 28);
    press_mode();                       // SET_YEAR
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1); check("set_year_pulse", int'(set_year), 1);
      step(0, 0, 0); check("set_year_drop", int'(set_year), 0);
    end
    check("set_year_day", int'(day), 28);
    check("set_year_month", int'(month), 2);
    press_mode();                       // RUN
    $display("scenario: month clamp + 3 set_year pulses, year now %0d", year_r);

    // Feb 29 invalidated by a year increment
    step(0, 0, 0);
    year_r = 16'd2024;
    set_date(29, 2);
    press_mode(); press_mode(); press_mode();
    step(0, 0, 1);                      // set_year pulse visible
    step(0, 0, 0);                      // year counter increments at this edge
    check("feb29_hold", int'(day), 29);
    step(0, 0, 0);                      // first edge seeing 2025
    check("feb29_clamp", int'(day), 28);
    press_mode();                       // RUN
    $display("scenario: feb29 year clamp, year now %0d", year_r);

    // simultaneous mode+inc in SET_DAY, tick ignored in SET_DAY
    press_mode();
    d0 = m_day;
    step(0, 1, 1);
    check("simul_mode", int'(mode), 2);
    check("simul_day", int'(day), d0);
    step(0, 0, 0);
    press_mode(); press_mode(); press_mode();   // SET_YEAR, RUN, SET_DAY
    step(1, 0, 0);
    check("tick_in_set_day", int'(day), d0);
    press_mode(); press_mode();                 // SET_YEAR
    step(0, 0, 1);
    check("pre_reset_set_year", int'(set_year), 1);
    do_reset();
    $display("scenario: simultaneous buttons, frozen tick, reset mid SET_YEAR");

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        year_r  = P_YEAR_W'(yrs[$urandom_range(0, 5)]);
        yr_pend = 0;
      end
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) == 0);
    end
    $display("scenario: 3000 random cycles, ends %0d/%0d mode %0d", day, month, mode);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
